// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units and the CDB arbiter: packed per-source result inputs,
// per-source ready/sent handshakes and the broadcast common data bus.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned PHYS_W  = 6,
  parameter int unsigned ROB_W   = 5
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*PHYS_W-1:0] src_pd;
  logic [NUM_SRC*5-1:0]      src_rd;
  logic [NUM_SRC*ROB_W-1:0]  src_rob_index;
  logic [NUM_SRC*32-1:0]     src_result;

  logic                      cdb_valid;
  logic [PHYS_W-1:0]         cdb_pd;
  logic [4:0]                cdb_rd;
  logic [ROB_W-1:0]          cdb_rob_index;
  logic [31:0]               cdb_result;
  logic [NUM_SRC-1:0]        cdb_sent;

  // Functional-unit side: produces results, observes ready and the broadcast.
  modport master (
    output src_valid, src_pd, src_rd, src_rob_index, src_result,
    input  src_ready, cdb_valid, cdb_pd, cdb_rd, cdb_rob_index, cdb_result, cdb_sent
  );

  // Arbiter side.
  modport slave (
    input  src_valid, src_pd, src_rd, src_rob_index, src_result,
    output src_ready, cdb_valid, cdb_pd, cdb_rd, cdb_rob_index, cdb_result, cdb_sent
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs, round-robin grant, registered CDB broadcast.
// Optional macro CDB_BYPASS_EN lets an empty source's input win the CDB at its own accept edge.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned PHYS_W  = 6,
  parameter int unsigned ROB_W   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [PHYS_W-1:0] pd;
    logic [RD_W-1:0]   rd;
    logic [ROB_W-1:0]  rob_index;
    logic [DATA_W-1:0] result;
  } cdb_entry_t;

  cdb_entry_t       fifo_mem   [NUM_SRC][DEPTH];
  logic [PTR_W-1:0] wr_ptr     [NUM_SRC];
  logic [PTR_W-1:0] wr_ptr_nxt [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr     [NUM_SRC];
  logic [PTR_W-1:0] rd_ptr_nxt [NUM_SRC];
  logic [CNT_W-1:0] cnt        [NUM_SRC];
  logic [CNT_W-1:0] cnt_nxt    [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr, rr_ptr_nxt;
  cdb_entry_t         cdb_q, cdb_nxt;
  logic               cdb_valid_q, cdb_valid_nxt;
  logic [NUM_SRC-1:0] cdb_sent_q, cdb_sent_nxt;

  cdb_entry_t         src_entry  [NUM_SRC];
  cdb_entry_t         head_entry [NUM_SRC];
  logic [NUM_SRC-1:0] src_ready;
  logic [NUM_SRC-1:0] occupied;
  logic [NUM_SRC-1:0] byp_req;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               found;
  logic [SRC_W-1:0]   gnt_idx;

  function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int unsigned k);
    return SRC_W'((32'(base) + k) % NUM_SRC);
  endfunction

  // Unpack the per-source input lanes and the FIFO heads.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_entry[i].pd        = bus.src_pd[i*PHYS_W +: PHYS_W];
      src_entry[i].rd        = bus.src_rd[i*RD_W +: RD_W];
      src_entry[i].rob_index = bus.src_rob_index[i*ROB_W +: ROB_W];
      src_entry[i].result    = bus.src_result[i*DATA_W +: DATA_W];
      head_entry[i]          = fifo_mem[i][rd_ptr[i]];
      src_ready[i]           = (cnt[i] != CNT_W'(DEPTH));
      occupied[i]            = (cnt[i] != '0);
    end
  end

  // Requesters: non-empty FIFOs, plus empty sources presenting a result when bypass is built in.
  always_comb begin
    byp_req = '0;
`ifdef CDB_BYPASS_EN
    byp_req = ~occupied & bus.src_valid & {NUM_SRC{~flush}};
`endif
    req = occupied | byp_req;
  end

  // Round-robin pick, CDB next state and FIFO pointer/count updates.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    cnt_nxt       = cnt;
    rr_ptr_nxt    = rr_ptr;
    cdb_nxt       = cdb_q;
    cdb_valid_nxt = 1'b0;
    cdb_sent_nxt  = '0;
    grant         = '0;
    push          = '0;
    pop           = '0;
    found         = 1'b0;
    gnt_idx       = '0;

    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found && !flush && req[rr_idx(rr_ptr, k)]) begin
        found   = 1'b1;
        gnt_idx = rr_idx(rr_ptr, k);
      end
    end

    if (found) begin
      grant[gnt_idx]        = 1'b1;
      cdb_valid_nxt         = 1'b1;
      cdb_sent_nxt[gnt_idx] = 1'b1;
      rr_ptr_nxt            = rr_idx(gnt_idx, 1);
      cdb_nxt               = occupied[gnt_idx] ? head_entry[gnt_idx] : src_entry[gnt_idx];
    end

    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      pop[i]  = grant[i] && occupied[i];
      // A bypassed result goes straight to the CDB and never occupies the FIFO.
      push[i] = bus.src_valid[i] && src_ready[i] && !flush && !(grant[i] && !occupied[i]);
      if (flush) begin
        wr_ptr_nxt[i] = '0;
        rd_ptr_nxt[i] = '0;
        cnt_nxt[i]    = '0;
      end else begin
        if (push[i]) wr_ptr_nxt[i] = wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_nxt[i] = rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_nxt[i] = cnt[i] + CNT_W'(1);
          2'b01:   cnt_nxt[i] = cnt[i] - CNT_W'(1);
          default: cnt_nxt[i] = cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '{default: '0};
      rd_ptr      <= '{default: '0};
      cnt         <= '{default: '0};
      rr_ptr      <= '0;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_sent_q  <= '0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      cnt         <= cnt_nxt;
      rr_ptr      <= rr_ptr_nxt;
      cdb_q       <= cdb_nxt;
      cdb_valid_q <= cdb_valid_nxt;
      cdb_sent_q  <= cdb_sent_nxt;
    end
  end

  // Result storage needs no reset; occupancy is tracked by the counts.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= src_entry[i];
    end
  end

  assign bus.src_ready     = src_ready;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_sent      = cdb_sent_q;
  assign bus.cdb_pd        = cdb_q.pd;
  assign bus.cdb_rd        = cdb_q.rd;
  assign bus.cdb_rob_index = cdb_q.rob_index;
  assign bus.cdb_result    = cdb_q.result;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus queues expected broadcasts,
// a negedge monitor matches every CDB beat against them.
module tb_cdb_arbiter;
  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned PHYS_W  = 6;
  localparam int unsigned ROB_W   = 5;

  typedef struct {
    int          src;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [4:0]  rob;
    logic [31:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .PHYS_W(PHYS_W), .ROB_W(ROB_W)) bus ();

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .PHYS_W(PHYS_W), .ROB_W(ROB_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   bp_phase = 1'b0;
  exp_t sb[$];
  int   lsq_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int s, input int n);
    exp_t e;
    e.src = s;
    e.pd  = 6'(s * 10 + n);
    e.rd  = 5'(s + n + 1);
    e.rob = 5'(s * 8 + n);
    e.res = 32'hC0DE_0000 + 32'(s * 256 + n);
    return e;
  endfunction

  task automatic set_src(input exp_t e);
    bus.src_pd[e.src*PHYS_W +: PHYS_W]      = e.pd;
    bus.src_rd[e.src*5 +: 5]                = e.rd;
    bus.src_rob_index[e.src*ROB_W +: ROB_W] = e.rob;
    bus.src_result[e.src*32 +: 32]          = e.res;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    int k = 0;
    while (!bus.cdb_valid && k < max) begin
      tick();
      k++;
    end
    check(name, 64'(bus.cdb_valid), 64'(1));
  endtask

  task automatic drain(input string name, input int max);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      tick();
      k++;
    end
    check(name, 64'(sb.size()), 64'(0));
    repeat (2) tick();
  endtask

  // Monitor: every broadcast must match the oldest outstanding entry of its source.
  always @(negedge clk) begin : monitor
    int   g;
    int   idx;
    exp_t e;
    if (rst) begin
      cyc++;
      if (bus.cdb_valid) begin
        check("cdb_sent_onehot", 64'($onehot(bus.cdb_sent)), 64'(1));
        g = -1;
        for (int i = 0; i < NUM_SRC; i++) if (bus.cdb_sent[i]) g = i;
        idx = -1;
        for (int j = 0; j < sb.size(); j++) if (idx < 0 && sb[j].src == g) idx = j;
        if (idx < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cdb_unexpected: got src %0d rob %0h result %h, required no broadcast",
                   g, bus.cdb_rob_index, bus.cdb_result);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          check("cdb_fields", 64'({bus.cdb_pd, bus.cdb_rd, bus.cdb_rob_index, bus.cdb_result}),
                64'({e.pd, e.rd, e.rob, e.res}));
          if (bp_phase && g == 2) lsq_cyc.push_back(cyc);
        end
      end else begin
        check("idle_sent", 64'(bus.cdb_sent), 64'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t       e;
    int         n [NUM_SRC];
    logic [3:0] bp_tab [6];
    logic [3:0] post_rst_ready;
    bp_tab = '{4'hF, 4'hF, 4'h2, 4'h4, 4'h8, 4'h1};

    // Reset with every source requesting.
    rst               = 1'b0;
    flush             = 1'b0;
    bus.src_valid     = 4'hF;
    bus.src_pd        = '0;
    bus.src_rd        = '0;
    bus.src_rob_index = '0;
    bus.src_result    = '0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
      check("rst_cdb_sent", 64'(bus.cdb_sent), 64'(0));
    end
    bus.src_valid = '0;
    #1 rst = 1'b1;
    tick();
    check("rst_src_ready", 64'(bus.src_ready), 64'(4'hF));

    // Contention: all four push together, rr_ptr at 0.
    for (int s = 0; s < NUM_SRC; s++) begin
      e = mk(s, 0);
      set_src(e);
      sb.push_back(e);
    end
    bus.src_valid = 4'hF;
    tick();
    bus.src_valid = '0;
    wait_valid("cont_first_valid", 5);
    for (int k = 0; k < NUM_SRC; k++) begin
      check("cont_sent_seq", 64'(bus.cdb_sent), 64'(1 << k));
      tick();
    end
    check("cont_idle_valid", 64'(bus.cdb_valid), 64'(0));
    drain("cont_drain", 10);

    // Single ALU result: latency and fields.
    e.src = 0; e.pd = 6'd5; e.rd = 5'd7; e.rob = 5'd3; e.res = 32'hDEADBEEF;
    set_src(e);
    sb.push_back(e);
    bus.src_valid = 4'b0001;
    tick();
    bus.src_valid = '0;
`ifdef CDB_BYPASS_EN
    check("lat_e0_valid", 64'(bus.cdb_valid), 64'(1));
    check("lat_e0_sent", 64'(bus.cdb_sent), 64'(4'b0001));
`else
    check("lat_e0_valid", 64'(bus.cdb_valid), 64'(0));
    tick();
    check("lat_e1_valid", 64'(bus.cdb_valid), 64'(1));
    check("lat_e1_sent", 64'(bus.cdb_sent), 64'(4'b0001));
`endif
    drain("single_drain", 10);

    // Backpressure: every source saturating for 6 cycles, rr_ptr at 1.
    for (int s = 0; s < NUM_SRC; s++) n[s] = 0;
    bp_phase = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int s = 0; s < NUM_SRC; s++) set_src(mk(s, n[s]));
      bus.src_valid = 4'hF;
      check("bp_src_ready", 64'(bus.src_ready), 64'(bp_tab[c]));
      for (int s = 0; s < NUM_SRC; s++) if (bp_tab[c][s]) sb.push_back(mk(s, n[s]));
      tick();
      for (int s = 0; s < NUM_SRC; s++) if (bp_tab[c][s]) n[s]++;
    end
    bus.src_valid = '0;
    drain("bp_drain", 40);
    bp_phase = 1'b0;
    check("bp_lsq_count", 64'(lsq_cyc.size()), 64'(3));
    if (lsq_cyc.size() == 3) begin
      check("bp_lsq_gap0", 64'(lsq_cyc[1] - lsq_cyc[0]), 64'(4));
      check("bp_lsq_gap1", 64'(lsq_cyc[2] - lsq_cyc[1]), 64'(4));
    end

    // Flush with two entries buffered per source, rr_ptr at 1.
    for (int s = 0; s < NUM_SRC; s++) set_src(mk(s, 4));
    sb.push_back(mk(1, 4));
    bus.src_valid = 4'hF;
    tick();
    for (int s = 0; s < NUM_SRC; s++) set_src(mk(s, 5));
    tick();
    for (int s = 0; s < NUM_SRC; s++) set_src(mk(s, 6));
    flush = 1'b1;
    tick();
    flush         = 1'b0;
    bus.src_valid = '0;
    check("flush_cdb_valid", 64'(bus.cdb_valid), 64'(0));
    check("flush_cdb_sent", 64'(bus.cdb_sent), 64'(0));
    check("flush_src_ready", 64'(bus.src_ready), 64'(4'hF));
    repeat (6) tick();
    check("flush_sb_empty", 64'(sb.size()), 64'(0));

    // rr_ptr survived the flush: next grant starts at source 2.
    for (int s = 0; s < NUM_SRC; s++) begin
      e = mk(s, 7);
      set_src(e);
      sb.push_back(e);
    end
    bus.src_valid = 4'hF;
    tick();
    bus.src_valid = '0;
    wait_valid("postflush_valid", 5);
    check("postflush_rr_hold", 64'(bus.cdb_sent), 64'(4'b0100));
    drain("postflush_drain", 10);

    // Async reset in the middle of a burst, rr_ptr at 2.
    for (int s = 0; s < NUM_SRC; s++) set_src(mk(s, 0));
    sb.push_back(mk(2, 0));
    bus.src_valid = 4'hF;
    tick();
    bus.src_valid = '0;
    tick();
    check("burst_sent", 64'(bus.cdb_sent), 64'(4'b0100));
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
    check("arst_cdb_sent", 64'(bus.cdb_sent), 64'(0));
    check("arst_cdb_result", 64'(bus.cdb_result), 64'(0));
    post_rst_ready = bus.src_ready;
    check("arst_src_ready", 64'(post_rst_ready), 64'(4'hF));
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) begin
      e = mk(s, 1);
      set_src(e);
      sb.push_back(e);
    end
    bus.src_valid = 4'hF;
    tick();
    bus.src_valid = '0;
    wait_valid("arst_resume_valid", 5);
    check("arst_resume_src0", 64'(bus.cdb_sent), 64'(4'b0001));
    drain("arst_drain", 10);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
